// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matrix-vector engine: FSM state encoding,
// accumulator saturation limits and index-width helpers.
package matvec_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StOutput
  } matvec_state_t;

  // Working width for the limit functions; any ACC_W up to this is supported.
  localparam int unsigned SatCalcW = 128;

  // Narrowest index width ever used on a port (a 1-entry range still gets 1 bit).
  localparam int unsigned MinIdxW = 1;

  // Index width for a range of n entries, never below MinIdxW.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : MinIdxW;
  endfunction

  // Largest signed value representable in acc_w bits.
  function automatic logic signed [SatCalcW-1:0] sat_max(int unsigned acc_w);
    return (128'sd1 <<< (acc_w - 1)) - 128'sd1;
  endfunction

  // Smallest signed value representable in acc_w bits.
  function automatic logic signed [SatCalcW-1:0] sat_min(int unsigned acc_w);
    return -(128'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/matvec_mac.sv
// Combinational signed multiply-accumulate with saturating add.
// Full-precision product, sign-extended to ACC_W, added to the running sum;
// overflow clamps to the ACC_W signed range instead of wrapping.
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned ACC_W  = 2 * DATA_W
) (
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_w,
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [ACC_W-1:0]  o_acc
);

  localparam logic signed [SatCalcW-1:0] SatMaxFull = sat_max(ACC_W);
  localparam logic signed [SatCalcW-1:0] SatMinFull = sat_min(ACC_W);
  localparam logic signed [ACC_W-1:0]    SatMax     = SatMaxFull[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0]    SatMin     = SatMinFull[ACC_W-1:0];

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W:0]      w_sum;

  // Multiply, extend, add one guard bit wide and clamp on overflow.
  always_comb begin
    w_prod     = i_x * i_w;
    w_prod_ext = ACC_W'(w_prod);
    w_sum      = (ACC_W + 1)'(i_acc) + (ACC_W + 1)'(w_prod_ext);
    // Guard bit disagreeing with the result MSB means the sum left the range.
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      o_acc = w_sum[ACC_W] ? SatMin : SatMax;
    end else begin
      o_acc = w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine: Y[r] = sum_c X[c]*W[r][c], one saturating MAC
// per cycle, one row result per valid/ready handshake.
// Optional build macro MATVEC_RELU_EN clamps negative row results to zero at the
// output register (accumulation itself stays signed and saturating).
module matvec_engine
  import matvec_pkg::*;
#(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned N      = 8,
  parameter int unsigned M      = 8,
  parameter int unsigned ACC_W  = 2 * DATA_W,
  localparam int unsigned ColW  = idx_w(N),
  localparam int unsigned WAddrW = idx_w(M * N),
  localparam int unsigned RowW  = idx_w(M)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] i_wr_data,
  input  logic                     i_wr_en_x,
  input  logic [ColW-1:0]          i_addr_x,
  input  logic                     i_wr_en_w,
  input  logic [WAddrW-1:0]        i_addr_w,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic signed [ACC_W-1:0]  o_out_data,
  output logic [RowW-1:0]          o_out_row,
  output logic                     o_out_last
);

  // Operand storage: not reset, survives i_rst.
  logic signed [DATA_W-1:0] r_x [N];
  logic signed [DATA_W-1:0] r_w [M*N];

  matvec_state_t r_state, w_state_next;

  logic [RowW-1:0]          r_row;
  logic [ColW-1:0]          r_col;
  // W is row-major, so the flat W index just advances by one per MAC across rows.
  logic [WAddrW-1:0]        r_widx;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_out_data;
  logic [RowW-1:0]          r_out_row;
  logic                     r_out_last;

  logic signed [ACC_W-1:0]  w_mac;
  logic signed [ACC_W-1:0]  w_out_val;
  logic                     w_col_last;
  logic                     w_row_last;

  assign w_col_last = (r_col == ColW'(N - 1));
  assign w_row_last = (r_row == RowW'(M - 1));

  matvec_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .i_x   (r_x[r_col]),
    .i_w   (r_w[r_widx]),
    .i_acc (r_acc),
    .o_acc (w_mac)
  );

  // Row result as it will be registered for the output stream.
  always_comb begin
`ifdef MATVEC_RELU_EN
    w_out_val = w_mac[ACC_W-1] ? '0 : w_mac;
`else
    w_out_val = w_mac;
`endif
  end

  // Operand writes, accepted only while idle; out-of-range addresses dropped.
  always_ff @(posedge i_clk) begin
    if (r_state == StIdle) begin
      if (i_wr_en_x && (32'(i_addr_x) < N)) begin
        r_x[i_addr_x] <= i_wr_data;
      end
      if (i_wr_en_w && (32'(i_addr_w) < M * N)) begin
        r_w[i_addr_w] <= i_wr_data;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (i_start) w_state_next = StCompute;
      StCompute: if (w_col_last) w_state_next = StOutput;
      StOutput: begin
        if (i_out_ready) begin
          w_state_next = w_row_last ? StIdle : StCompute;
        end
      end
      default:   w_state_next = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy      = 1'b0;
    o_out_valid = 1'b0;
    unique case (r_state)
      StIdle:    ;
      StCompute: o_busy = 1'b1;
      StOutput: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
      end
      default:   ;
    endcase
  end

  // Counters, accumulator and held output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_widx     <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_row  <= '0;
      r_out_last <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_row  <= '0;
            r_col  <= '0;
            r_widx <= '0;
            r_acc  <= '0;
          end
        end
        StCompute: begin
          r_acc <= w_mac;
          r_col <= r_col + ColW'(1);
          // Hold the pointer on the very last MAC so it never leaves the array.
          if (!(w_col_last && w_row_last)) begin
            r_widx <= r_widx + WAddrW'(1);
          end
          if (w_col_last) begin
            r_col      <= '0;
            r_out_data <= w_out_val;
            r_out_row  <= r_row;
            r_out_last <= w_row_last;
          end
        end
        StOutput: begin
          if (i_out_ready && !w_row_last) begin
            r_row <= r_row + RowW'(1);
            r_col <= '0;
            r_acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_data = r_out_data;
  assign o_out_row  = r_out_row;
  assign o_out_last = r_out_last;

endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine: default-size instance plus a small
// N=3/M=1/DATA_W=8 instance checked against a saturating reference model.
module tb_matvec_engine;

  localparam int unsigned DW = 14;
  localparam int unsigned NN = 8;
  localparam int unsigned MM = 8;
  localparam int unsigned AW = 28;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-size instance
  logic signed [DW-1:0] wr_data;
  logic                 wr_en_x, wr_en_w, start, out_ready;
  logic [2:0]           addr_x;
  logic [5:0]           addr_w;
  logic                 busy, out_valid, out_last;
  logic signed [AW-1:0] out_data;
  logic [2:0]           out_row;

  // Small instance
  logic signed [7:0]  s_wr_data;
  logic               s_wr_en_x, s_wr_en_w, s_start, s_out_ready;
  logic [1:0]         s_addr_x, s_addr_w;
  logic               s_busy, s_out_valid, s_out_last;
  logic signed [15:0] s_out_data;
  logic [0:0]         s_out_row;

  int checks = 0;
  int errors = 0;

  logic signed [63:0] exp_y [MM];
  longint sx [3];
  longint sw [3];

  matvec_engine #(
    .DATA_W (DW),
    .N      (NN),
    .M      (MM),
    .ACC_W  (AW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_data   (wr_data),
    .i_wr_en_x   (wr_en_x),
    .i_addr_x    (addr_x),
    .i_wr_en_w   (wr_en_w),
    .i_addr_w    (addr_w),
    .i_start     (start),
    .o_busy      (busy),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_row   (out_row),
    .o_out_last  (out_last)
  );

  matvec_engine #(
    .DATA_W (8),
    .N      (3),
    .M      (1),
    .ACC_W  (16)
  ) dut_s (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_data   (s_wr_data),
    .i_wr_en_x   (s_wr_en_x),
    .i_addr_x    (s_addr_x),
    .i_wr_en_w   (s_wr_en_w),
    .i_addr_w    (s_addr_w),
    .i_start     (s_start),
    .o_busy      (s_busy),
    .o_out_valid (s_out_valid),
    .i_out_ready (s_out_ready),
    .o_out_data  (s_out_data),
    .o_out_row   (s_out_row),
    .o_out_last  (s_out_last)
  );

  function automatic longint relu(input longint v);
`ifdef MATVEC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Reference for the small instance: sequential saturating 16-bit accumulate.
  function automatic longint model_small();
    longint acc = 0;
    for (int c = 0; c < 3; c++) begin
      acc = acc + sx[c] * sw[c];
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
    end
    return relu(acc);
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_x(input int a, input longint d);
    wr_en_x = 1'b1; addr_x = 3'(a); wr_data = 14'(d);
    tick();
    wr_en_x = 1'b0;
  endtask

  task automatic wr_w(input int a, input longint d);
    wr_en_w = 1'b1; addr_w = 6'(a); wr_data = 14'(d);
    tick();
    wr_en_w = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Collect all M rows; stall_row < 0 means no stall.
  task automatic collect(input string tag, input int first_lat, input int stall_row);
    int n;
    for (int r = 0; r < int'(MM); r++) begin
      n = 0;
      while (!out_valid && n < 200) begin
        tick();
        n++;
      end
      check({tag, "_lat"}, n, (r == 0) ? first_lat : int'(NN));
      check({tag, "_data"}, out_data, exp_y[r]);
      check({tag, "_row"}, out_row, r);
      check({tag, "_last"}, out_last, (r == int'(MM) - 1) ? 1 : 0);
      if (r == stall_row) begin
        out_ready = 1'b0;
        repeat (20) tick();
        check({tag, "_stall_valid"}, out_valid, 1);
        check({tag, "_stall_busy"}, busy, 1);
        check({tag, "_stall_data"}, out_data, exp_y[r]);
        check({tag, "_stall_row"}, out_row, r);
        out_ready = 1'b1;
      end
      tick();
    end
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int n;
    longint tmp;
    rst = 1'b1;
    wr_data = '0; wr_en_x = 1'b0; wr_en_w = 1'b0; addr_x = '0; addr_w = '0;
    start = 1'b0; out_ready = 1'b1;
    s_wr_data = '0; s_wr_en_x = 1'b0; s_wr_en_w = 1'b0; s_addr_x = '0; s_addr_w = '0;
    s_start = 1'b0; s_out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_row", out_row, 0);
    check("rst_last", out_last, 0);

    // X=1, W[r][c]=r; row 1 of W written in the same cycles as X.
    for (int c = 0; c < int'(NN); c++) begin
      wr_en_x = 1'b1; addr_x = 3'(c);
      wr_en_w = 1'b1; addr_w = 6'(NN + c);
      wr_data = 14'sd1;
      tick();
    end
    wr_en_x = 1'b0; wr_en_w = 1'b0;
    for (int r = 0; r < int'(MM); r++) begin
      if (r != 1) begin
        for (int c = 0; c < int'(NN); c++) wr_w(r * NN + c, r);
      end
      exp_y[r] = relu(8 * r);
    end
    pulse_start();
    check("t1_busy_start", busy, 1);
    collect("t1", 8, -1);

    // Back-pressure on row 2
    pulse_start();
    collect("stall", 8, 2);

    // start and W write mid-compute must be ignored
    pulse_start();
    repeat (3) tick();
    start = 1'b1; wr_en_w = 1'b1; addr_w = 6'd0; wr_data = 14'sd999;
    tick();
    start = 1'b0; wr_en_w = 1'b0;
    collect("midc", 4, -1);

    // Reset while holding a result, then rerun from retained storage
    pulse_start();
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check("abort_reach_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", out_data, 0);
    check("abort_row", out_row, 0);
    pulse_start();
    collect("retain", 8, -1);

    // Mixed-sign rows: W[r][c]=r-4; last W write shares its cycle with start.
    for (int i = 0; i < int'(NN * MM) - 1; i++) wr_w(i, (i / NN) - 4);
    for (int r = 0; r < int'(MM); r++) exp_y[r] = relu(8 * (r - 4));
    wr_en_w = 1'b1; addr_w = 6'd63; wr_data = 14'sd3; start = 1'b1;
    tick();
    wr_en_w = 1'b0; start = 1'b0;
    collect("mixed", 8, -1);

    // Positive saturation
    for (int c = 0; c < int'(NN); c++) wr_x(c, 8191);
    for (int i = 0; i < int'(NN * MM); i++) wr_w(i, 8191);
    for (int r = 0; r < int'(MM); r++) exp_y[r] = relu(134217727);
    pulse_start();
    collect("psat", 8, -1);

    // Negative saturation
    for (int c = 0; c < int'(NN); c++) wr_x(c, -8192);
    for (int r = 0; r < int'(MM); r++) exp_y[r] = relu(-134217728);
    pulse_start();
    collect("nsat", 8, -1);

    // Small instance vs reference model
    for (int t = 0; t < 12; t++) begin
      for (int c = 0; c < 3; c++) begin
        if (t == 0) begin
          sx[c] = -128; sw[c] = -128;
        end else if (t == 1) begin
          sx[c] = 127; sw[c] = -128;
        end else begin
          sx[c] = longint'($urandom_range(255)) - 128;
          sw[c] = longint'($urandom_range(255)) - 128;
        end
        s_wr_en_x = 1'b1; s_addr_x = 2'(c); s_wr_data = 8'(sx[c]);
        tick();
        s_wr_en_x = 1'b0;
        s_wr_en_w = 1'b1; s_addr_w = 2'(c); s_wr_data = 8'(sw[c]);
        tick();
        s_wr_en_w = 1'b0;
      end
      // Out-of-range addresses carry junk and must not disturb anything.
      s_wr_en_x = 1'b1; s_wr_en_w = 1'b1; s_addr_x = 2'd3; s_addr_w = 2'd3;
      s_wr_data = 8'sh55;
      tick();
      s_wr_en_x = 1'b0; s_wr_en_w = 1'b0;
      tmp = model_small();
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      n = 0;
      while (!s_out_valid && n < 50) begin
        tick();
        n++;
      end
      check("small_lat", n, 3);
      check("small_data", s_out_data, tmp);
      check("small_row", s_out_row, 0);
      check("small_last", s_out_last, 1);
      tick();
      check("small_busy_end", s_busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matvec_engine.md
# matvec_engine

Parametrised matrix-vector multiply engine: holds an N-element signed input vector X and an M×N signed weight matrix W, then on `start` computes all M row dot products Y[r] = Σc X[c]·W[r][c] with one multiply-accumulate per cycle and saturating accumulation. Each row result is emitted on a valid/ready output stream. It is the successor to the fixed 8-lane, single-accumulate datapath: it is generalised in width, vector length and row count, and adds its own sequencer FSM and output back-pressure.

## Interface
- `DATA_W`, 14, signed width of X and W elements
- `N`, 8, vector length (columns), ≥2
- `M`, 8, matrix rows, ≥1
- `ACC_W`, 2*DATA_W, signed accumulator/output width, ≥2*DATA_W

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_data`  in  DATA_W  signed write data for X/W
- `wr_en_x`  in  1  write `wr_data` to X[`addr_x`]
- `addr_x`  in  $clog2(N)  X element index
- `wr_en_w`  in  1  write `wr_data` to W at flat index `addr_w` = r*N+c
- `addr_w`  in  $clog2(M*N)  W flat index
- `start`  in  1  begin computation (sampled in IDLE only)
- `busy`  out  1  high in COMPUTE/OUTPUT
- `out_valid`  out  1  row result available
- `out_ready`  in  1  consumer accepts result
- `out_data`  out  ACC_W  signed row result
- `out_row`  out  $clog2(M) (min 1)  row index of `out_data`
- `out_last`  out  1  `out_data` is row M-1

## Operation
- FSM states: IDLE, COMPUTE, OUTPUT.
- IDLE:
  - Writes are accepted.
  - `start`=1 → COMPUTE with row=0, col=0, acc=0.
- COMPUTE:
  - Each cycle: acc ← sat(acc + X[col]·W[row][col]); col++.
  - At col=N-1 the last MAC is taken and the FSM moves to OUTPUT.
- OUTPUT:
  - `out_valid`=1; `out_data`, `out_row` and `out_last` are held stable.
  - On `out_valid`&&`out_ready`: if row=M-1 → IDLE; else row++, col=0, acc=0, → COMPUTE.
- Arithmetic:
  - Product is a full-precision 2*DATA_W signed value, sign-extended to ACC_W.
  - Each addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; there is no wrap.
- Writes:
  - Ignored while `busy`.
  - `addr_w` ≥ M*N and `addr_x` ≥ N are ignored.
  - If `wr_en_x` and `wr_en_w` are both asserted in the same cycle, both writes occur.
- Storage:
  - Reads are combinational.
  - X and W are not reset; contents survive `rst`.
- `start` while busy is ignored. `start` asserted together with writes in IDLE: the writes land, then the compute uses the new values.

## Timing
- Reset values: state=IDLE, `busy`=0, `out_valid`=0, `out_data`=0, `out_row`=0, `out_last`=0, acc=0.
- `rst` mid-operation aborts immediately at the next edge; no partial result is emitted.
- Latency:
  - `start` sampled at edge k → `busy` high after edge k.
  - MACs at edges k+1…k+N.
  - `out_valid` high after edge k+N.
- Output handshake and throughput:
  - Each accepted row costs N+1 cycles; a full run takes M·(N+1) cycles with `out_ready` tied high.
  - `out_ready` low stalls indefinitely with outputs stable.
  - `out_valid` never drops without a handshake, except on `rst`.
- `busy` falls the edge after the last handshake; a new `start` is accepted the cycle after that.

## Configuration
- `MATVEC_RELU_EN` defined: `out_data` = max(acc, 0). The clamp is applied at the output register only; accumulation still saturates signed.
- Undefined: `out_data` = acc, signed.

## Structure
- Package `matvec_pkg`:
  - state enum `matvec_state_t`
  - saturation limit constant functions of ACC_W
  - index-width helper localparams
- Sub-module `matvec_mac`: combinational DATA_W×DATA_W signed multiply plus ACC_W saturating add.
- The engine top holds storage, counters, FSM and output registers.

## Test plan
- Default parameters, X=all 1, W[r][c]=r. Run with `out_ready`=1 → rows 0..7 output 0,8,16,…,56. `out_last` high only on row 7. First `out_valid` comes 8 cycles after `start`.
- X=all 8191, W=all 8191, ACC_W=28 → every row outputs 134217727 (positive saturation). X=-8192, W=8191 → every row outputs -134217728.
- Same negative case with `MATVEC_RELU_EN` defined → every output is 0. Mixed-sign rows pass positive sums unchanged.
- Hold `out_ready`=0 for 20 cycles on row 2 → `out_data`/`out_row` stay stable and `busy` stays high; release → row 3 computes next.
- Assert `start` and `wr_en_w` mid-COMPUTE → both ignored, results unchanged. Assert `rst` while in OUTPUT → next cycle `out_valid`=0, `busy`=0. Then `start` without rewriting → identical results from the retained X/W.
- Parameter sweep N=3, M=1, DATA_W=8 with random data vs a reference model → bit-exact outputs, including saturation.
